// File: rtl/speed_cfg_pkg.sv
// rtl/speed_cfg_pkg.sv - speed codes, sequencer state type and sizing helper
package speed_cfg_pkg;

    localparam logic [1:0] SPEED_10M   = 2'b00;
    localparam logic [1:0] SPEED_100M  = 2'b01;
    localparam logic [1:0] SPEED_1000M = 2'b10;
    localparam logic [1:0] SPEED_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUIESCE = 3'd1,
        ST_RESET   = 3'd2,
        ST_APPLY   = 3'd3,
        ST_SETTLE  = 3'd4
    } seq_state_t;

    // Largest of three cycle parameters; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/speed_stable_filter.sv
// rtl/speed_stable_filter.sv - accepts a speed code once it has been sampled unchanged STABLE_CYCLES times
module speed_stable_filter
    import speed_cfg_pkg::*;
#(
    parameter int         STABLE_CYCLES = 16,
    parameter logic [1:0] RESET_VAL     = SPEED_1000M
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed_in,
    output logic [1:0] stable_val
);

    localparam int            CW      = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [1:0]    prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    stable_q, stable_d;

    // Run length of the current sample value; a new value restarts the run at one
    // because the edge that sees it already counts as its first sample.
    always_comb begin
        prev_d   = speed_in;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (speed_in != prev_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
        if (cnt_d == CNT_MAX) begin
            stable_d = speed_in;
        end
    end

    // Filter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= RESET_VAL;
            cnt_q    <= '0;
            stable_q <= RESET_VAL;
        end else begin
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_val = stable_q;

endmodule

// File: rtl/speed_change_sequencer.sv
// rtl/speed_change_sequencer.sv - quiesce/reset/apply/settle sequencer for MAC speed changes (SPEED_SEQ_CHANGE_CNT_EN adds change_cnt)
module speed_change_sequencer
    import speed_cfg_pkg::*;
#(
    parameter int         STABLE_CYCLES  = 16,
    parameter int         RST_CYCLES     = 32,
    parameter int         SETTLE_CYCLES  = 64,
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [1:0] DEFAULT_SPEED  = 2'b10
) (
    input  logic       out_clk,
    input  logic       out_reset,
    input  logic [1:0] speed_in,
    input  logic       mac_idle,
    output logic       mac_hold,
    output logic       mac_rst,
    output logic [1:0] speed_out,
    output logic       busy,
    output logic       timeout_err,
    output logic       rsvd_err
`ifdef SPEED_SEQ_CHANGE_CNT_EN
    ,
    output logic [7:0] change_cnt
`endif
);

    localparam int            CW          = $clog2(max3(RST_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)) + 1;
    localparam logic [CW-1:0] QUIET_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    logic [1:0]    stable_val;

    seq_state_t    state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [1:0]    target_q, target_d;
    logic [1:0]    speed_out_q, speed_out_d;
    logic          mac_hold_q, mac_hold_d;
    logic          mac_rst_q, mac_rst_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;
    logic          rsvd_err_q, rsvd_err_d;

    speed_stable_filter #(
        .STABLE_CYCLES (STABLE_CYCLES),
        .RESET_VAL     (DEFAULT_SPEED)
    ) u_filter (
        .clk        (out_clk),
        .rst        (out_reset),
        .speed_in   (speed_in),
        .stable_val (stable_val)
    );

    // Next state, phase counter and sticky flags. The target is captured only when
    // leaving IDLE so input changes mid-sequence wait for the next IDLE evaluation.
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q;
        target_d      = target_q;
        speed_out_d   = speed_out_q;
        timeout_err_d = timeout_err_q;
        rsvd_err_d    = rsvd_err_q | (stable_val == SPEED_RSVD);
        case (state_q)
            ST_IDLE: begin
                if ((stable_val != speed_out_q) && (stable_val != SPEED_RSVD)) begin
                    state_d  = ST_QUIESCE;
                    target_d = stable_val;
                    cyc_d    = '0;
                end
            end
            ST_QUIESCE: begin
                if (mac_idle) begin
                    state_d = ST_RESET;
                    cyc_d   = '0;
                end else if (cyc_q == QUIET_LAST) begin
                    state_d       = ST_RESET;
                    cyc_d         = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_RESET: begin
                if (cyc_q == RST_LAST) begin
                    state_d     = ST_APPLY;
                    cyc_d       = '0;
                    speed_out_d = target_q;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            ST_APPLY: begin
                state_d = ST_SETTLE;
                cyc_d   = '0;
            end
            ST_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    state_d = ST_IDLE;
                    cyc_d   = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        mac_hold_d = (state_d != ST_IDLE);
        mac_rst_d  = (state_d == ST_RESET);
        busy_d     = (state_d != ST_IDLE);
    end

    // Sequencer registers; reset aborts any sequence with no partial speed update.
    always_ff @(posedge out_clk or posedge out_reset) begin
        if (out_reset) begin
            state_q       <= ST_IDLE;
            cyc_q         <= '0;
            target_q      <= DEFAULT_SPEED;
            speed_out_q   <= DEFAULT_SPEED;
            mac_hold_q    <= 1'b0;
            mac_rst_q     <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            rsvd_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            target_q      <= target_d;
            speed_out_q   <= speed_out_d;
            mac_hold_q    <= mac_hold_d;
            mac_rst_q     <= mac_rst_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            rsvd_err_q    <= rsvd_err_d;
        end
    end

    assign mac_hold    = mac_hold_q;
    assign mac_rst     = mac_rst_q;
    assign speed_out   = speed_out_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign rsvd_err    = rsvd_err_q;

`ifdef SPEED_SEQ_CHANGE_CNT_EN
    logic [7:0] change_cnt_q, change_cnt_d;

    // Count applied speed changes, holding at the maximum.
    always_comb begin
        change_cnt_d = change_cnt_q;
        if ((state_d == ST_APPLY) && (change_cnt_q != 8'hFF)) begin
            change_cnt_d = change_cnt_q + 8'd1;
        end
    end

    // Change counter register.
    always_ff @(posedge out_clk or posedge out_reset) begin
        if (out_reset) begin
            change_cnt_q <= 8'd0;
        end else begin
            change_cnt_q <= change_cnt_d;
        end
    end

    assign change_cnt = change_cnt_q;
`endif

endmodule

// File: doc/speed_change_sequencer.md
SPEED_CHANGE_SEQUENCER -- requirements
Module: speed_change_sequencer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, meaning consecutive identical samples before speed_in is accepted (min 1).
REQ-002 SHALL have parameter RST_CYCLES, default 32, meaning mac_rst pulse width in cycles (min 1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 64, meaning post-apply hold time before release (min 1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning max wait for mac_idle in QUIESCE (min 1).
REQ-005 SHALL have parameter DEFAULT_SPEED, default 2'b10, meaning speed_out value after reset.
REQ-006 SHALL have port out_clk input 1, the single clock; one clock, no other clock domain.
REQ-007 SHALL have port out_reset input 1, the reset; asynchronous, active-high.
REQ-008 SHALL have port speed_in input 2, already-synchronized speed code: 00=10M, 01=100M, 10=1000M, 11=reserved.
REQ-009 SHALL have port mac_idle input 1, high when the MAC has no frame in flight.
REQ-010 SHALL have port mac_hold output 1, request to stop new frame starts.
REQ-011 SHALL have port mac_rst output 1, MAC datapath reset, active-high.
REQ-012 SHALL have port speed_out output 2, applied speed code.
REQ-013 SHALL have port busy output 1, high in any state other than IDLE.
REQ-014 SHALL have port timeout_err output 1, sticky; set on QUIESCE timeout.
REQ-015 SHALL have port rsvd_err output 1, sticky; set when a stable 2'b11 is accepted.

Function
REQ-016 SHALL run a stability filter: counter clears when speed_in differs from the previous sample; stable_val updates on the edge at which speed_in has been equal for STABLE_CYCLES consecutive edges.
REQ-017 SHALL ignore stable_val 2'b11 (no sequence) and set rsvd_err.
REQ-018 SHALL use FSM states IDLE, QUIESCE, RESET, APPLY, SETTLE.
REQ-019 IDLE -> QUIESCE on the cycle after stable_val != speed_out (non-reserved); target latched at that transition.
REQ-020 QUIESCE: mac_hold=1; -> RESET on the cycle mac_idle=1, or after TIMEOUT_CYCLES cycles (sets timeout_err, still proceeds).
REQ-021 RESET: mac_hold=1, mac_rst=1 for exactly RST_CYCLES cycles, then -> APPLY.
REQ-022 APPLY: single cycle; speed_out <= latched target; mac_rst=0, mac_hold=1; -> SETTLE.
REQ-023 SETTLE: mac_hold=1 for SETTLE_CYCLES cycles, then -> IDLE with mac_hold=0.
REQ-024 Changes on speed_in during a sequence SHALL NOT alter the latched target; re-evaluated in IDLE after completion.
REQ-025 A change back to the current speed_out before the filter accepts it SHALL start no sequence.
REQ-026 All outputs SHALL be registered; cycle counters sized $clog2(max parameter)+1 and never wrap.

Reset
REQ-027 While out_reset=1: state=IDLE, speed_out=DEFAULT_SPEED, stable_val=DEFAULT_SPEED, mac_hold=0, mac_rst=0, busy=0, timeout_err=0, rsvd_err=0, all counters 0.
REQ-028 Reset asserted mid-sequence SHALL abort immediately to reset values; no partial speed_out update.

Configuration
REQ-029 With SPEED_SEQ_CHANGE_CNT_EN defined: extra output change_cnt (8 bits), incremented in APPLY, saturating at 255, reset 0.
REQ-030 Without SPEED_SEQ_CHANGE_CNT_EN: port and counter absent; all other behaviour identical.

Structure
REQ-031 Shared package speed_cfg_pkg SHALL hold speed code constants (SPEED_10M/100M/1000M/RSVD) and FSM state typedef.
REQ-032 Stability filter SHALL be sub-module speed_stable_filter (parameter STABLE_CYCLES); FSM in the top.

Verification (STABLE_CYCLES=4, RST_CYCLES=8, SETTLE_CYCLES=16, TIMEOUT_CYCLES=64, DEFAULT_SPEED=10)
REQ-033 Reset release, speed_in=10 held -> no busy, speed_out=10 forever, both error flags 0.
REQ-034 speed_in 10->01, mac_idle=1 -> mac_hold rises 5 cycles after change, mac_rst high exactly 8 cycles, speed_out=01 after, mac_hold falls 16 cycles after APPLY.
REQ-035 speed_in glitches to 00 for 3 cycles then back to 10 -> no sequence, busy stays 0.
REQ-036 speed_in 10->00, mac_idle=0 -> RESET entered after 64 QUIESCE cycles, timeout_err=1 sticky, speed_out=00.
REQ-037 speed_in=11 stable -> rsvd_err=1, speed_out unchanged; then 01 mid-RESET of a 00 sequence -> 00 applied first, then second sequence to 01.
REQ-038 out_reset asserted during RESET state -> mac_rst, mac_hold drop same cycle (async), speed_out=10.
